// File: rtl/demo_cmd_dec.sv
// Multi-channel command-stream decoder: parses header+payload packets, forwards
// payload beats through one output register stage, drops malformed packets.
module demo_cmd_dec #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [7:0]              out_ch,
  output logic [7:0]              out_op,
  output logic                    out_last,
  output logic                    out_empty,
  output logic                    err_pulse,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [CH_NUM*CNT_W-1:0] pkt_cnt
);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_e;

  state_e state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [7:0] ch_q, ch_d;
  logic [7:0] op_q, op_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [7:0]        out_ch_q, out_ch_d;
  logic [7:0]        out_op_q, out_op_d;
  logic              out_last_q, out_last_d;
  logic              out_empty_q, out_empty_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  pkt_q [CH_NUM];

  logic [7:0] hdr_op, hdr_len, hdr_ch;
  logic       hdr_bad;
  logic       in_fire, out_fire;

  assign hdr_op  = in_data[7:0];
  assign hdr_len = in_data[15:8];
  assign hdr_ch  = in_data[23:16];
  assign hdr_bad = (32'(hdr_ch) >= CH_NUM) || (32'(hdr_len) > MAX_LEN);

  // Drop state never produces output, so it need not wait on the output register.
  assign in_ready = (state_q == S_DROP) || !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_HDR;
      remain_q <= 8'd0;
      ch_q     <= 8'd0;
      op_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ch_q     <= ch_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ch_d     = ch_q;
    op_d     = op_q;
    if (in_fire) begin
      case (state_q)
        S_HDR: begin
          if (hdr_bad) begin
            remain_d = hdr_len;
            state_d  = (hdr_len == 8'd0) ? S_HDR : S_DROP;
          end else if (hdr_len != 8'd0) begin
            remain_d = hdr_len;
            ch_d     = hdr_ch;
            op_d     = hdr_op;
            state_d  = S_PAY;
          end
        end
        S_PAY, S_DROP: begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_op_d    = out_op_q;
    out_last_d  = out_last_q;
    out_empty_d = out_empty_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (in_fire) begin
      case (state_q)
        S_HDR: begin
          if (hdr_bad) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
          end else if (hdr_len == 8'd0) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_ch_d    = hdr_ch;
            out_op_d    = hdr_op;
            out_last_d  = 1'b1;
            out_empty_d = 1'b1;
          end
        end
        S_PAY: begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_ch_d    = ch_q;
          out_op_d    = op_q;
          out_last_d  = (remain_q == 8'd1);
          out_empty_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= 8'd0;
      out_op_q    <= 8'd0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_op_q    <= out_op_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Per-channel delivered-packet counters, bumped when a last beat is taken.
  for (genvar c = 0; c < CH_NUM; c++) begin : g_pkt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pkt_q[c] <= '0;
      end else if (out_fire && out_last_q && (out_ch_q == 8'(c))) begin
        pkt_q[c] <= pkt_q[c] + CNT_W'(1);
      end
    end
    assign pkt_cnt[c*CNT_W +: CNT_W] = pkt_q[c];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_op    = out_op_q;
  assign out_last  = out_last_q;
  assign out_empty = out_empty_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demo_cmd_dec.sv
// Bench for demo_cmd_dec: directed scenarios plus random packet streams checked
// against a packet-level scoreboard model.
module tb_demo_cmd_dec;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CH_NUM  = 4;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = 8;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  ch;
    logic [7:0]  op;
    logic        last;
    logic        empty;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [7:0] out_ch, out_op;
  logic out_last, out_empty, err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CH_NUM*CNT_W-1:0] pkt_cnt;

  demo_cmd_dec #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_op(out_op), .out_last(out_last), .out_empty(out_empty), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: packet-level parse of every accepted word.
  beat_t exp_q[$];
  beat_t obs_q[$];
  int m_rem = 0;
  bit m_good = 0;
  logic [7:0] m_ch, m_op;
  logic [CNT_W-1:0] exp_err = '0;
  logic [CNT_W-1:0] exp_pkt [CH_NUM];
  int exp_pulses = 0;
  int obs_pulses = 0;
  bit acc;

  function automatic logic [31:0] hdr(input int ch, input int len, input int op);
    logic [7:0] junk;
    junk = 8'($urandom);
    return {junk, 8'(ch), 8'(len), 8'(op)};
  endfunction

  task automatic model_accept(input logic [31:0] w);
    beat_t b;
    int ch, len;
    if (m_rem == 0) begin
      ch  = int'(w[23:16]);
      len = int'(w[15:8]);
      if (ch >= CH_NUM || len > MAX_LEN) begin
        if (exp_err != {CNT_W{1'b1}}) exp_err = exp_err + 1'b1;
        exp_pulses++;
        m_good = 0;
        m_rem  = len;
      end else if (len == 0) begin
        b.data = '0; b.ch = w[23:16]; b.op = w[7:0]; b.last = 1'b1; b.empty = 1'b1;
        exp_q.push_back(b);
        exp_pkt[ch] = exp_pkt[ch] + 1'b1;
      end else begin
        m_good = 1; m_rem = len; m_ch = w[23:16]; m_op = w[7:0];
      end
    end else begin
      if (m_good) begin
        b.data = w; b.ch = m_ch; b.op = m_op; b.last = (m_rem == 1); b.empty = 1'b0;
        exp_q.push_back(b);
        if (m_rem == 1) exp_pkt[int'(m_ch)] = exp_pkt[int'(m_ch)] + 1'b1;
      end
      m_rem--;
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); obs_q.delete();
    m_rem = 0; m_good = 0; exp_err = '0; exp_pulses = 0; obs_pulses = 0;
    for (int c = 0; c < CH_NUM; c++) exp_pkt[c] = '0;
  endtask

  // One clock: drive at negedge, record handshakes, return at the next negedge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r);
    beat_t b;
    in_valid = v; in_data = d; out_ready = r;
    #1;
    acc = v && in_ready;
    if (out_valid && r) begin
      b.data = out_data; b.ch = out_ch; b.op = out_op; b.last = out_last; b.empty = out_empty;
      obs_q.push_back(b);
    end
    @(posedge clk);
    if (acc) model_accept(d);
    @(negedge clk);
    if (err_pulse) obs_pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_clear();
    #2;
    checks++;
    if ({out_valid, out_data, out_ch, out_op, out_last, out_empty, err_pulse} !== '0) begin
      errors++; $display("FAIL reset_out got v=%b d=%h ch=%h op=%h l=%b e=%b p=%b required all 0",
        out_valid, out_data, out_ch, out_op, out_last, out_empty, err_pulse);
    end
    checks++;
    if (err_cnt !== '0 || pkt_cnt !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cnt got err=%h pkt=%h rdy=%b required 0/0/1", err_cnt, pkt_cnt, in_ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_good();
    logic [31:0] w [3];
    beat_t e, o;
    w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'hC;
    cycle(1, hdr(2, 3, 8'h5A), 1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL good_hdr_no_out got out_valid=%b required 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, w[i], 1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[i] || out_last !== (i == 2) || out_ch !== 8'd2 ||
          out_op !== 8'h5A || out_empty !== 1'b0) begin
        errors++; $display("FAIL good_beat%0d got v=%b d=%h l=%b ch=%h op=%h required 1/%h/%b/02/5a",
          i, out_valid, out_data, out_last, out_ch, out_op, w[i], i == 2);
      end
    end
    cycle(0, '0, 1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL good_sb got %h required %h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL good_sb_left got obs=%0d exp=%0d required 0/0", obs_q.size(), exp_q.size());
    end
    checks++;
    if (pkt_cnt[2*CNT_W +: CNT_W] !== exp_pkt[2]) begin
      errors++; $display("FAIL good_pkt2 got %0d required %0d", pkt_cnt[2*CNT_W +: CNT_W], exp_pkt[2]);
    end
  endtask

  task automatic test_zero();
    cycle(1, hdr(0, 0, 8'h33), 1);
    checks++;
    if (out_valid !== 1'b1 || out_empty !== 1'b1 || out_last !== 1'b1 || out_data !== '0 ||
        out_ch !== 8'd0 || out_op !== 8'h33) begin
      errors++; $display("FAIL zero_beat got v=%b e=%b l=%b d=%h ch=%h op=%h required 1/1/1/0/00/33",
        out_valid, out_empty, out_last, out_data, out_ch, out_op);
    end
    cycle(1, hdr(1, 1, 8'h11), 1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_next_hdr got out_valid=%b required 0", out_valid); end
    cycle(1, 32'hDEAD, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD || out_ch !== 8'd1 || out_last !== 1'b1) begin
      errors++; $display("FAIL zero_follow got v=%b d=%h ch=%h l=%b required 1/dead/01/1", out_valid, out_data, out_ch, out_last);
    end
    cycle(0, '0, 1);
    checks++;
    if (pkt_cnt[0 +: CNT_W] !== exp_pkt[0] || pkt_cnt[1*CNT_W +: CNT_W] !== exp_pkt[1]) begin
      errors++; $display("FAIL zero_pkt got c0=%0d c1=%0d required %0d/%0d",
        pkt_cnt[0 +: CNT_W], pkt_cnt[1*CNT_W +: CNT_W], exp_pkt[0], exp_pkt[1]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bad();
    bit rdy_ok = 1;
    bit quiet = 1;
    int p0 = obs_pulses;
    cycle(1, hdr(4, 2, 8'h07), 0);
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== exp_err) begin
      errors++; $display("FAIL bad_err got pulse=%b cnt=%0d required 1/%0d", err_pulse, err_cnt, exp_err);
    end
    for (int i = 0; i < 2; i++) begin
      if (in_ready !== 1'b1) rdy_ok = 0;
      cycle(1, 32'h1234_0000 + 32'(i), 0);
      if (!acc || out_valid !== 1'b0 || err_pulse !== 1'b0) quiet = 0;
    end
    checks++;
    if (!rdy_ok || !quiet) begin errors++; $display("FAIL bad_drop got ready_ok=%b quiet=%b required 1/1", rdy_ok, quiet); end
    checks++;
    if (obs_pulses - p0 != 1) begin errors++; $display("FAIL bad_pulses got %0d required 1", obs_pulses - p0); end
    cycle(1, hdr(3, 1, 8'h66), 1);
    cycle(1, 32'hBEEF, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hBEEF || out_ch !== 8'd3 || out_op !== 8'h66) begin
      errors++; $display("FAIL bad_recover got v=%b d=%h ch=%h op=%h required 1/beef/03/66", out_valid, out_data, out_ch, out_op);
    end
    cycle(0, '0, 1);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_oversize();
    bit quiet = 1;
    cycle(1, hdr(1, 17, 8'h42), 1);
    for (int i = 0; i < 17; i++) begin
      cycle(1, 32'($urandom), 1);
      if (!acc || out_valid !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet || err_cnt !== exp_err || obs_pulses != exp_pulses) begin
      errors++; $display("FAIL oversize got quiet=%b cnt=%0d pulses=%0d required 1/%0d/%0d",
        quiet, err_cnt, obs_pulses, exp_err, exp_pulses);
    end
    cycle(1, hdr(2, 0, 8'h01), 1);
    checks++;
    if (out_valid !== 1'b1 || out_empty !== 1'b1) begin
      errors++; $display("FAIL oversize_next got v=%b e=%b required 1/1", out_valid, out_empty);
    end
    cycle(0, '0, 1);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] w [5];
    logic [31:0] held;
    beat_t e, o;
    int idx = 0;
    int k = 0;
    bit stall_ok = 1;
    w[0] = hdr(3, 4, 8'hC3);
    for (int i = 1; i < 5; i++) w[i] = 32'($urandom);
    while (idx < 5 && k < 40) begin
      if (k >= 3 && k < 8) begin
        held = out_data;
        cycle(1, w[idx], 0);
        if (acc || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) stall_ok = 0;
      end else begin
        cycle(1, w[idx], 1);
      end
      if (acc) idx++;
      k++;
    end
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    checks++;
    if (!stall_ok || idx != 5) begin errors++; $display("FAIL bp_stall got stall_ok=%b sent=%0d required 1/5", stall_ok, idx); end
    checks++;
    if (obs_q.size() != 4 || exp_q.size() != 4) begin
      errors++; $display("FAIL bp_count got obs=%0d exp=%0d required 4/4", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL bp_sb got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    cycle(1, hdr(1, 3, 8'h21), 1);
    cycle(1, 32'h5555, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || out_ch !== 8'd0 ||
        err_cnt !== '0 || pkt_cnt !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got v=%b d=%h ch=%h err=%h pkt=%h rdy=%b required 0/0/0/0/0/1",
        out_valid, out_data, out_ch, err_cnt, pkt_cnt, in_ready);
    end
    model_clear();
    @(negedge clk); rst = 1'b0;
    cycle(1, hdr(2, 0, 8'h77), 1);
    checks++;
    if (out_valid !== 1'b1 || out_empty !== 1'b1 || out_ch !== 8'd2 || out_op !== 8'h77) begin
      errors++; $display("FAIL rst_next_hdr got v=%b e=%b ch=%h op=%h required 1/1/02/77", out_valid, out_empty, out_ch, out_op);
    end
    cycle(0, '0, 1);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] stream[$];
    beat_t e, o;
    int len, budget;
    for (int p = 0; p < 60; p++) begin
      len = ($urandom % 5 != 0) ? int'($urandom_range(0, MAX_LEN)) : int'($urandom_range(0, 24));
      stream.push_back(hdr(int'($urandom_range(0, 5)), len, int'($urandom % 256)));
      for (int i = 0; i < len; i++) stream.push_back(32'($urandom));
    end
    budget = 0;
    while (stream.size() > 0 && budget < 20000) begin
      cycle($urandom % 4 != 0, stream[0], $urandom % 3 != 0);
      if (acc) void'(stream.pop_front());
      budget++;
    end
    for (int i = 0; i < 3; i++) cycle(0, '0, 1);
    checks++;
    if (stream.size() != 0 || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_count got left=%0d obs=%0d exp=%0d required 0 and equal", stream.size(), obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rnd_sb got %h required %h", o, e); end
    end
    checks++;
    if (err_cnt !== exp_err || obs_pulses != exp_pulses) begin
      errors++; $display("FAIL rnd_err got cnt=%0d pulses=%0d required %0d/%0d", err_cnt, obs_pulses, exp_err, exp_pulses);
    end
    for (int c = 0; c < CH_NUM; c++) begin
      checks++;
      if (pkt_cnt[c*CNT_W +: CNT_W] !== exp_pkt[c]) begin
        errors++; $display("FAIL rnd_pkt%0d got %0d required %0d", c, pkt_cnt[c*CNT_W +: CNT_W], exp_pkt[c]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 270; i++) cycle(1, hdr(9, 0, 0), 1);
    checks++;
    if (err_cnt !== exp_err || err_cnt !== {CNT_W{1'b1}}) begin
      errors++; $display("FAIL sat_err got %h required %h", err_cnt, exp_err);
    end
    cycle(1, hdr(200, 0, 0), 1);
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== {CNT_W{1'b1}}) begin
      errors++; $display("FAIL sat_hold got pulse=%b cnt=%h required 1/ff", err_pulse, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_zero();
    test_bad();
    test_oversize();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demo_cmd_dec.md
# demo_cmd_dec

Parametrised multi-channel command-stream decoder for the demo subsystem. Consumes a valid/ready word stream of header + payload packets and checks each header. Routes payload words to a registered output stream tagged with channel and opcode sidebands. Drops malformed packets and keeps per-channel packet counters and an error counter for status readback.

## Interface
- DATA_W, default 32: stream word width; must be >= 24.
- CH_NUM, default 4: number of valid channels, 1..256.
- MAX_LEN, default 16: maximum payload words per packet, 0..255.
- CNT_W, default 16: width of each packet counter and of the error counter.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DATA_W  header or payload word.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  payload word; 0 on empty beat.
- out_ch  out  8  channel of the current packet.
- out_op  out  8  opcode of the current packet.
- out_last  out  1  last beat of the packet.
- out_empty  out  1  beat stands for a zero-length packet.
- err_pulse  out  1  one-cycle pulse per dropped packet.
- err_cnt  out  CNT_W  dropped packets, saturating.
- pkt_cnt  out  CH_NUM*CNT_W  per-channel delivered packets, channel c at [c*CNT_W +: CNT_W], wrapping.

## Operation
- Header word fields: op = in_data[7:0], len = in_data[15:8], ch = in_data[23:16]. Bits above 23 are ignored.
- FSM states: S_HDR (reset), S_PAY, S_DROP.
- S_HDR, header accepted:
  - If ch >= CH_NUM or len > MAX_LEN: the packet is bad. Go to S_DROP with remain = len, or stay in S_HDR if len == 0. Pulse err_pulse and increment err_cnt; err_cnt saturates at all-ones.
  - Else if len == 0: load one output beat with out_data=0, out_last=1, out_empty=1, out_ch=ch, out_op=op. Stay in S_HDR.
  - Else: latch ch and op, set remain = len, go to S_PAY.
- S_PAY, payload word accepted: load an output beat with in_data, out_last = (remain == 1), out_empty=0. Decrement remain. Go to S_HDR after the last word.
- S_DROP, word accepted: decrement remain and produce no output. Go to S_HDR when remain reaches 0.
- in_ready = (state == S_DROP) || !out_valid || out_ready. Words are never lost or duplicated under backpressure.
- pkt_cnt[out_ch] increments on every handshake with out_last=1, including empty beats. The counter wraps.

## Timing
- Reset values: state=S_HDR, out_valid=0, out_data/out_ch/out_op/out_last/out_empty=0, err_pulse=0, err_cnt=0, all pkt_cnt=0, in_ready=1.
- Latency: an accepted word appears on the output the next cycle. The output is a single register stage.
- Throughput: one word per cycle when out_ready is held 1. A header costs one input cycle with no output, except for zero-length packets.
- Output handshake: out_valid stays high and the payload/sideband outputs stay stable until out_ready. A new beat may load in the same cycle the old one is taken.
- err_pulse is asserted in the cycle after the bad header handshake.
- Simultaneous counter events: an increment and a saturated err_cnt leave err_cnt at all-ones.
- Reset mid-packet: all state clears immediately. The next accepted word is treated as a header. A pending output beat is discarded.

## Test plan
- Good packet: header ch=2, op=0x5A, len=3, payload A,B,C with out_ready=1 -> 3 beats, each one cycle after input, out_last on C only, all tagged ch=2 op=0x5A; pkt_cnt[2]=1.
- Zero-length: header ch=0, len=0 -> one beat with out_empty=1, out_last=1, out_data=0; pkt_cnt[0]=1; no payload expected; next word is decoded as a header.
- Bad channel: header ch=4 (CH_NUM=4), len=2, then 2 words -> no output, err_pulse once, err_cnt=1, in_ready=1 throughout; a following good header decodes normally.
- Oversize: header len=17 (MAX_LEN=16) -> 17 words dropped, err_cnt increments by 1. Also preload err_cnt to 0xFFFF -> it stays 0xFFFF.
- Backpressure: out_ready held 0 for 5 cycles mid-payload of a len=4 packet -> in_ready low, out_data stable, no loss; all 4 beats arrive in order when released.
- Reset mid-payload: assert rst after 1 of 3 payload words -> outputs go to reset values at once; the next word after reset is decoded as a header.
